// File: rtl/floo_endsim_pkg.sv
// -----------------------------------------------------------------------------
// floo_endsim_pkg
// Shared types and helpers for the FlooNoC end-of-simulation monitor.
//   endsim_state_e : monitor FSM state encoding
//   MinTiles       : smallest legal NumTiles
//   MaxCores       : widest per-tile core vector tile_all_done() accepts
//   tile_all_done  : AND-reduce of the low num_cores bits of a flag vector
// -----------------------------------------------------------------------------
package floo_endsim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_FINISH  = 3'd3,
        ST_TIMEOUT = 3'd4
    } endsim_state_e;

    localparam int unsigned MinTiles = 1;
    localparam int unsigned MaxCores = 64;

    // Bits at or above num_cores are don't-care, so callers may zero-extend
    // a narrower core vector into the fixed MaxCores-wide argument.
    function automatic logic tile_all_done(input logic [MaxCores-1:0] flags,
                                           input int unsigned         num_cores);
        logic all_set;
        all_set = 1'b1;
        for (int unsigned i = 0; i < MaxCores; i++) begin
            if ((i < num_cores) && !flags[i]) begin
                all_set = 1'b0;
            end
        end
        return all_set;
    endfunction

endpackage

// File: rtl/floo_endsim_tile_tracker.sv
// -----------------------------------------------------------------------------
// floo_endsim_tile_tracker
// Per-tile completion tracker: AND-reduces the tile's core end flags, holds a
// sticky done flag, and captures the tile error flag and the cycle count on
// the done edge.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   end_of_sim_i    per-core end flags of this tile
//   error_i         tile error flag, captured together with done
//   capture_en_i    monitor is in a state where completions are recorded
//   clear_i         synchronous clear of all captured state
//   cycle_cnt_i     current monitor cycle count (timestamp source)
//   hit_o           combinational: tile completes this cycle
//   done_o          sticky done flag
//   err_o           captured error flag
//   done_cycle_o    captured timestamp
// -----------------------------------------------------------------------------
module floo_endsim_tile_tracker
    import floo_endsim_pkg::*;
#(
    parameter int unsigned NumCores = 9,
    parameter int unsigned CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumCores-1:0] end_of_sim_i,
    input  logic                error_i,
    input  logic                capture_en_i,
    input  logic                clear_i,
    input  logic [CntWidth-1:0] cycle_cnt_i,
    output logic                hit_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CntWidth-1:0] done_cycle_o
);

    logic [MaxCores-1:0] flags_ext;
    logic                all_done;
    logic                done_d, done_q;
    logic                err_d, err_q;
    logic [CntWidth-1:0] stamp_d, stamp_q;

    assign flags_ext = MaxCores'(end_of_sim_i);
    assign all_done  = tile_all_done(flags_ext, NumCores);

    // Only the first completion counts; later re-assertions must not move
    // the timestamp or re-sample the error flag.
    assign hit_o = capture_en_i && all_done && !done_q;

    always_comb begin
        done_d  = done_q;
        err_d   = err_q;
        stamp_d = stamp_q;
        if (clear_i) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            stamp_d = '0;
        end else if (hit_o) begin
            done_d  = 1'b1;
            err_d   = error_i;
            stamp_d = cycle_cnt_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stamp_q <= '0;
        end else begin
            done_q  <= done_d;
            err_q   <= err_d;
            stamp_q <= stamp_d;
        end
    end

    assign done_o       = done_q;
    assign err_o        = err_q;
    assign done_cycle_o = stamp_q;

endmodule

// File: rtl/floo_endsim_monitor.sv
// -----------------------------------------------------------------------------
// floo_endsim_monitor
// Generic end-of-simulation controller for FlooNoC tile-array benches.
// Watches NumTiles x NumCores end flags, decides completion in all/any mode,
// waits DrainCycles, then signals finish; an optional watchdog ends the run
// with a timeout instead.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for enable_i; end flags ignored
//   ST_RUN     | counting cycles, capturing tiles, watchdog armed
//   ST_DRAIN   | completion seen; counting down DrainCycles, still capturing
//   ST_FINISH  | run completed; everything frozen until clear_i
//   ST_TIMEOUT | watchdog expired; everything frozen until clear_i
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   enable_i             start request (IDLE only)
//   clear_i              return to IDLE (FINISH/TIMEOUT only)
//   end_of_sim_i         per-core end flags, tile t at [t*NumCores +: NumCores]
//   error_i              per-tile error flags
//   tile_done_o          sticky per-tile done
//   tile_done_cycle_o    per-tile done timestamps, tile t at [t*CntWidth +: CntWidth]
//   running_o/draining_o state == RUN / DRAIN
//   finish_o             one-cycle pulse on entry to FINISH
//   done_o / timeout_o   state == FINISH / TIMEOUT
//   fail_o               any captured error, or timeout
//   cycle_cnt_o          saturating RUN/DRAIN cycle count
// -----------------------------------------------------------------------------
module floo_endsim_monitor
    import floo_endsim_pkg::*;
#(
    parameter int unsigned NumTiles      = 4,
    parameter int unsigned NumCores      = 9,
    parameter bit          AnyMode       = 1'b0,
    parameter int unsigned DrainCycles   = 100,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned CntWidth      = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic [NumTiles*NumCores-1:0] end_of_sim_i,
    input  logic [NumTiles-1:0]          error_i,
    output logic [NumTiles-1:0]          tile_done_o,
    output logic [NumTiles*CntWidth-1:0] tile_done_cycle_o,
    output logic                         running_o,
    output logic                         draining_o,
    output logic                         finish_o,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic                         fail_o,
    output logic [CntWidth-1:0]          cycle_cnt_o
);

    if (NumTiles < MinTiles) begin : g_bad_num_tiles
        $error("floo_endsim_monitor: NumTiles must be at least 1");
    end
    if (NumCores > MaxCores) begin : g_bad_num_cores
        $error("floo_endsim_monitor: NumCores exceeds MaxCores");
    end

    localparam int unsigned         DrainW      = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;
    localparam logic [DrainW-1:0]   DrainLoad   = DrainW'(DrainCycles);
    localparam logic [CntWidth-1:0] TimeoutLast = (TimeoutCycles == 0) ? '0
                                                : CntWidth'(TimeoutCycles - 1);

    endsim_state_e       state_d, state_q;
    logic [CntWidth-1:0] cycle_cnt_d, cycle_cnt_q;
    logic [DrainW-1:0]   drain_cnt_d, drain_cnt_q;
    logic                finish_d, finish_q;

    logic [NumTiles-1:0] tile_hit;
    logic [NumTiles-1:0] tile_done;
    logic [NumTiles-1:0] tile_err;
    logic [NumTiles-1:0] tile_reached;
    logic                capture_en;
    logic                clear_all;
    logic                cond;

    assign capture_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign clear_all  = clear_i && ((state_q == ST_FINISH) || (state_q == ST_TIMEOUT));

    for (genvar t = 0; t < NumTiles; t++) begin : g_tile
        floo_endsim_tile_tracker #(
            .NumCores (NumCores),
            .CntWidth (CntWidth)
        ) i_tracker (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .end_of_sim_i (end_of_sim_i[t*NumCores +: NumCores]),
            .error_i      (error_i[t]),
            .capture_en_i (capture_en),
            .clear_i      (clear_all),
            .cycle_cnt_i  (cycle_cnt_q),
            .hit_o        (tile_hit[t]),
            .done_o       (tile_done[t]),
            .err_o        (tile_err[t]),
            .done_cycle_o (tile_done_cycle_o[t*CntWidth +: CntWidth])
        );
    end

    // Including this cycle's hits lets the FSM react in the completion cycle
    // itself rather than one cycle after the sticky flags update.
    assign tile_reached = tile_done | tile_hit;
    assign cond         = AnyMode ? (|tile_reached) : (&tile_reached);

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        drain_cnt_d = drain_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d     = ST_RUN;
                    cycle_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (cond) begin
                    if (DrainCycles == 0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DrainLoad;
                    end
                end else if ((TimeoutCycles != 0) && (cycle_cnt_q == TimeoutLast)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q == DrainW'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH, ST_TIMEOUT: begin
                if (clear_i) begin
                    state_d     = ST_IDLE;
                    cycle_cnt_d = '0;
                    drain_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cycle_cnt_d = '0;
                drain_cnt_d = '0;
            end
        endcase

        finish_d = (state_d == ST_FINISH) && (state_q != ST_FINISH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            drain_cnt_q <= '0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            finish_q    <= finish_d;
        end
    end

    // Outputs decode directly from flops, no combinational input paths.
    assign tile_done_o = tile_done;
    assign running_o   = (state_q == ST_RUN);
    assign draining_o  = (state_q == ST_DRAIN);
    assign finish_o    = finish_q;
    assign done_o      = (state_q == ST_FINISH);
    assign timeout_o   = (state_q == ST_TIMEOUT);
    assign fail_o      = (|tile_err) || (state_q == ST_TIMEOUT);
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: doc/floo_endsim_monitor.md
Name: floo_endsim_monitor

Overview:
- Parametrised end-of-simulation controller for FlooNoC tile-array benches.
- Replaces hard-coded per-tile AND reductions of cluster end_of_sim with a generic block.
- Covers N tiles × M cores, sticky per-tile completion, all/any completion mode, configurable drain delay, timeout watchdog, per-tile error capture and cycle stamping.
- Sits in the bench next to the DUT; its outputs drive the $finish / exit-code logic.

Parameters:
- NumTiles, 4, number of compute tiles monitored (≥1)
- NumCores, 9, cores per tile; a tile is done when all its cores assert end_of_sim
- AnyMode, 1'b0, 0 = finish when all tiles are done, 1 = finish when any tile is done
- DrainCycles, 100, cycles to wait after the completion condition before finish (0 allowed)
- TimeoutCycles, 0, watchdog limit in RUN cycles; 0 disables the watchdog
- CntWidth, 32, width of the cycle counter and the timestamps

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- enable_i  in  1  IDLE->RUN start request
- clear_i  in  1  return to IDLE from FINISH/TIMEOUT, clearing all state
- end_of_sim_i  in  NumTiles*NumCores  per-core end flags; tile t uses bits [t*NumCores +: NumCores]
- error_i  in  NumTiles  per-tile error flag, sampled on the tile's done edge
- tile_done_o  out  NumTiles  sticky per-tile done
- tile_done_cycle_o  out  NumTiles*CntWidth  cycle_cnt value captured at each tile's done edge
- running_o  out  1  state==RUN
- draining_o  out  1  state==DRAIN
- finish_o  out  1  one-cycle pulse on entry to FINISH
- done_o  out  1  level, state==FINISH
- timeout_o  out  1  level, state==TIMEOUT
- fail_o  out  1  OR of captured errors, or timeout
- cycle_cnt_o  out  CntWidth  RUN cycle count, saturating

Behaviour:
- Reset: state=IDLE; all outputs, counters, sticky flags, error captures and timestamps are 0.
- States: IDLE, RUN, DRAIN, FINISH, TIMEOUT. All outputs are registered.
- IDLE: end flags are ignored. If enable_i is high -> RUN next cycle, with cycle_cnt=0.
- RUN: cycle_cnt increments each cycle and saturates at all-ones.
  - tile_hit[t] = &end_of_sim_i[tile t] && !tile_done_o[t].
  - On tile_hit, the next cycle shows tile_done_o[t]=1, timestamp[t]=cycle_cnt of the hit cycle, err[t]=error_i[t].
  - Flags are sticky: a deasserting end_of_sim does not clear them.
  - cond = AnyMode ? |(tile_done|tile_hit) : &(tile_done|tile_hit), evaluated combinationally in the same cycle.
  - If cond: go to DRAIN with drain_cnt=DrainCycles, or go directly to FINISH when DrainCycles=0.
  - Else if TimeoutCycles≠0 and cycle_cnt==TimeoutCycles-1: go to TIMEOUT.
  - cond and timeout in the same cycle: cond wins.
- DRAIN: drain_cnt decrements each cycle; on the cycle drain_cnt==1 -> FINISH.
  - Latency from the cond cycle to done_o high is DrainCycles+1 cycles.
  - Tile capture continues in DRAIN. cycle_cnt keeps counting. The watchdog is ignored.
- FINISH: finish_o is high for exactly the first cycle only. done_o is held. Tile capture and cycle_cnt are frozen.
- TIMEOUT: timeout_o and fail_o are held. Frozen like FINISH.
- clear_i: in FINISH or TIMEOUT -> IDLE next cycle, clearing flags, timestamps, errors and counters. clear_i is ignored in IDLE, RUN and DRAIN.
- enable_i is ignored outside IDLE.
- fail_o = |err | (state==TIMEOUT).
- Asynchronous reset mid-operation returns everything to the reset values immediately.
- A simultaneous hit on several tiles captures them all in the same cycle with identical timestamps.

Decomposition:
- floo_endsim_pkg holds: state enum endsim_state_e; helper function tile_all_done(flags, NumCores); localparam check NumTiles≥1.
- One natural sub-module: floo_endsim_tile_tracker, one instance per tile, generate loop. It holds the AND-reduce, sticky done, error capture and timestamp register.
- The top level holds the FSM, cycle counter, drain counter and watchdog.

Test Plan:
- All-mode basic:
  - Stimulus: NumTiles=4, NumCores=2, DrainCycles=3; enable at cycle 0; tiles reach all-ones at RUN cycles 10, 20, 15, 30.
  - Required: timestamps 10, 20, 15, 30; draining_o for cycles 31–33; finish_o pulses at cycle 34; done_o stays high; fail_o=0.
- Any-mode:
  - Stimulus: AnyMode=1; tile 2 done at cycle 5, error_i[2]=1 at that edge.
  - Required: FINISH after DrainCycles+1; fail_o=1; tile_done_o=4'b0100.
- Partial/sticky:
  - Stimulus: one core of tile 0 never asserts; tile 1 pulses end flags for one cycle.
  - Required: tile_done_o[1] stays 1; tile_done_o[0] stays 0.
  - With TimeoutCycles=50: timeout_o rises at cycle 50; fail_o=1; done_o=0.
- Race:
  - Stimulus: last tile completes exactly at cycle TimeoutCycles-1.
  - Required: DRAIN is entered, not TIMEOUT.
  - Separately, with DrainCycles=0: finish_o is high the cycle after cond.
- Clear/restart and reset:
  - Stimulus: clear_i in FINISH; enable_i again; rerun.
  - Required: all flags and timestamps are 0 in IDLE; the second run timestamps from 0.
  - rst_ni pulsed mid-DRAIN: all outputs 0 immediately, state IDLE.
